// File: rtl/mem_burst_if.sv
// Command, write-data, read-data and memory-port signals of the burst controller.
// slave is the controller side, master is the requester/memory side.
interface mem_burst_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready, mem_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready, mem_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst controller: turns address/length commands into single-beat memory accesses,
// passing write beats straight through and buffering read data in a 2-entry FIFO.
module mem_burst_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_burst_if.slave    bus
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_cur_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_inflight;
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_cmd_ready;
  logic              w_cmd_fire;
  logic              w_wr_beat;
  logic              w_pop;
  logic              w_push;
  logic              w_rd_issue;
  logic              w_issue;
  logic [CNT_W-1:0]  w_count_nxt;

  // cmd_ready is gated by reset so it stays low while held and rises as soon as it releases
  assign w_cmd_ready = (r_state == S_IDLE) & rst_n;
  assign w_cmd_fire  = bus.cmd_valid & w_cmd_ready;
  assign w_wr_beat   = (r_state == S_WRITE) & bus.wr_valid;
  assign w_pop       = (r_count != '0) & bus.rd_ready;
  assign w_push      = r_inflight;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Issue only when the word can be guaranteed a FIFO slot on arrival
  assign w_rd_issue  = (r_state == S_READ) &&
                       ((3'(r_count) + 3'(r_inflight)) < (3'd2 + 3'(w_pop)));
  assign w_issue     = w_wr_beat | w_rd_issue;

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.wr_ready  = (r_state == S_WRITE);
  assign bus.rd_valid  = (r_count != '0);
  assign bus.rd_data   = r_fifo[r_rptr];
  assign bus.mem_addr  = r_cur_addr;
  assign bus.mem_we    = w_wr_beat;
  assign bus.mem_wdata = w_wr_beat ? bus.wr_data : '0;
  assign bus.busy      = (r_state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd_fire) w_state_nxt = bus.cmd_we ? S_WRITE : S_READ;
      S_WRITE: if (w_wr_beat && (r_remaining == '0)) w_state_nxt = S_IDLE;
      S_READ:  if (w_rd_issue && (r_remaining == '0)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!r_inflight && (w_count_nxt == '0)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Burst address/length tracking and read-return FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_cmd_fire) begin
        r_cur_addr  <= bus.cmd_addr;
        r_remaining <= bus.cmd_len;
      end else if (w_issue) begin
        r_cur_addr  <= r_cur_addr + ADDR_W'(1);
        r_remaining <= r_remaining - LEN_W'(1);
      end
      r_inflight <= w_rd_issue;
      if (w_push) begin
        r_fifo[r_wptr] <= bus.mem_rdata;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Randomised bench for mem_burst_ctrl: a behavioural memory plus a shadow copy of
// every written word; reads are scored against the shadow in burst order.
module tb_mem_burst_ctrl;

  logic clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;
  int last_wait = 0;

  logic [31:0] mem_arr [0:65535];
  logic [31:0] shadow [logic [15:0]];
  logic [31:0] wq [$];

  mem_burst_if #(.ADDR_W(16), .DATA_W(32), .LEN_W(8)) bus ();

  mem_burst_ctrl #(.ADDR_W(16), .DATA_W(32), .LEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream memory: synchronous write, read data valid the cycle after the address
  always @(posedge clk) begin
    if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem_arr[bus.mem_addr];
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_cmd(input logic we, input logic [15:0] a, input logic [7:0] l);
    int waited;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    waited = 0;
    while (waited < 50) begin
      #1;
      if (bus.cmd_ready) break;
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    last_wait = waited;
    chk_eq("cmd_accept", 32'(waited < 50), 32'd1);
  endtask

  task automatic write_burst(input logic [15:0] a, input int len, input int stall_at,
                             input int stall_len);
    logic [15:0] ea;
    logic [31:0] d;
    logic        v;
    int beat, cyc, gap, st;
    send_cmd(1'b1, a, 8'(len));
    ea = a; beat = 0; cyc = 0; gap = stall_len; st = 0;
    d = (wq.size() > 0) ? wq.pop_front() : $urandom;
    while (beat <= len && cyc < 1000) begin
      v = !(beat == stall_at && gap > 0);
      bus.wr_valid = v;
      bus.wr_data  = d;
      #1;
      chk_eq("wr_busy", 32'(bus.busy), 32'd1);
      chk_eq("wr_cmd_hold", 32'(bus.cmd_ready), 32'd0);
      chk_eq("wr_rd_valid", 32'(bus.rd_valid), 32'd0);
      if (v) begin
        chk_eq("wr_ready", 32'(bus.wr_ready), 32'd1);
        chk_eq("wr_mem_we", 32'(bus.mem_we), 32'd1);
        chk_eq("wr_mem_addr", 32'(bus.mem_addr), 32'(ea));
        chk_eq("wr_mem_wdata", bus.mem_wdata, d);
        chk_eq("wr_cycle", 32'(cyc), 32'(beat + st));
        shadow[ea] = d;
        ea = ea + 16'd1;
        beat++;
        if (beat <= len) d = (wq.size() > 0) ? wq.pop_front() : $urandom;
      end else begin
        chk_eq("wr_stall_we", 32'(bus.mem_we), 32'd0);
        gap--;
        st++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.wr_valid = 1'b0;
    chk_eq("wr_beats", 32'(beat), 32'(len + 1));
    #1;
    chk_eq("wr_end_busy", 32'(bus.busy), 32'd0);
    chk_eq("wr_end_cmd_ready", 32'(bus.cmd_ready), 32'd1);
  endtask

  // mode 0: rd_ready=1, mode 1: 1-0-0-1 pattern, mode 2: random; abort_after>0 stops early
  task automatic read_burst(input logic [15:0] a, input int len, input int mode,
                            input int abort_after);
    logic [31:0] exp_q [$];
    logic [31:0] pd, e;
    logic [15:0] t;
    logic        rdy, stalled;
    int cyc, got;
    for (int i = 0; i <= len; i++) begin
      t = a + 16'(i);
      exp_q.push_back(shadow[t]);
    end
    send_cmd(1'b0, a, 8'(len));
    cyc = 0; got = 0; stalled = 1'b0; pd = '0;
    while (got <= len && cyc < 2000 && (abort_after == 0 || got < abort_after)) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.rd_ready = rdy;
      #1;
      chk_eq("rd_mem_we", 32'(bus.mem_we), 32'd0);
      chk_eq("rd_cmd_hold", 32'(bus.cmd_ready), 32'd0);
      chk_eq("rd_fifo_bound", 32'(dut.r_count <= 2'd2), 32'd1);
      if (stalled) begin
        chk_eq("rd_stall_valid", 32'(bus.rd_valid), 32'd1);
        chk_eq("rd_stall_data", bus.rd_data, pd);
      end
      if (bus.rd_valid && rdy) begin
        e = exp_q.pop_front();
        chk_eq("rd_data", bus.rd_data, e);
        if (mode == 0) chk_eq("rd_cycle", 32'(cyc), 32'(got + 2));
        got++;
      end
      stalled = bus.rd_valid && !rdy;
      pd = bus.rd_data;
      @(negedge clk);
      cyc++;
    end
    if (abort_after == 0) begin
      bus.rd_ready = 1'b0;
      chk_eq("rd_beats", 32'(got), 32'(len + 1));
      #1;
      chk_eq("rd_end_busy", 32'(bus.busy), 32'd0);
      chk_eq("rd_end_valid", 32'(bus.rd_valid), 32'd0);
      chk_eq("rd_end_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra;
    int rl;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    for (int i = 0; i < 65536; i++) mem_arr[i] = '0;

    repeat (3) @(negedge clk);
    #1;
    chk_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk_eq("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk_eq("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk_eq("rst_busy", 32'(bus.busy), 32'd0);
    chk_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk_eq("rst_rd_data", bus.rd_data, 32'd0);
    chk_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk_eq("rst_fifo_count", 32'(dut.r_count), 32'd0);
    chk_eq("rst_inflight", 32'(dut.r_inflight), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_eq("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);

    // Directed write and read-back
    wq.push_back(32'h7654_3210); wq.push_back(32'h1111_1111);
    wq.push_back(32'h2222_2222); wq.push_back(32'h3333_3333);
    write_burst(16'h0000, 3, -1, 0);
    read_burst(16'h0000, 3, 0, 0);

    // Address wrap
    write_burst(16'hFFFE, 3, -1, 0);
    read_burst(16'hFFFE, 3, 0, 0);

    // Write stall mid-burst, then backpressured reads
    write_burst(16'h0010, 7, 3, 3);
    read_burst(16'h0010, 7, 1, 0);
    read_burst(16'h0010, 7, 2, 0);

    // Single-beat bursts
    write_burst(16'h0100, 0, -1, 0);
    read_burst(16'h0100, 0, 0, 0);
    read_burst(16'h0100, 0, 2, 0);

    // Randomised bursts
    for (int r = 0; r < 8; r++) begin
      ra = 16'($urandom);
      rl = $urandom_range(0, 15);
      write_burst(ra, rl, $urandom_range(0, rl), $urandom_range(0, 3));
      read_burst(ra, rl, (r % 2 == 0) ? 2 : 0, 0);
    end

    // Reset in the middle of a read burst
    read_burst(16'h0010, 7, 0, 2);
    rst_n = 1'b0;
    #1;
    chk_eq("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk_eq("abort_busy", 32'(bus.busy), 32'd0);
    chk_eq("abort_mem_we", 32'(bus.mem_we), 32'd0);
    chk_eq("abort_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    bus.rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    write_burst(16'h0200, 2, -1, 0);
    chk_eq("post_rst_accept_wait", 32'(last_wait), 32'd0);
    read_burst(16'h0200, 2, 0, 0);
    read_burst(16'h0010, 7, 0, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
